// File: rtl/ps2_keyboard_if.sv
// CPU-facing keyboard data port: pop/clear strobes in, scancode head and status out.
interface ps2_keyboard_if;
    logic       rd;
    logic       clr;
    logic [7:0] data;
    logic       ready;
    logic       irq;
    logic       frame_err;
    logic       overflow;

    modport master (
        output rd,
        output clr,
        input  data,
        input  ready,
        input  irq,
        input  frame_err,
        input  overflow
    );

    modport slave (
        input  rd,
        input  clr,
        output data,
        output ready,
        output irq,
        output frame_err,
        output overflow
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronizes the pins, deframes 11-bit frames,
// checks parity/stop, and queues good scancodes in a show-ahead FIFO.
module ps2_keyboard #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TIMEOUT    = 25000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_keyboard_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic          clk_meta_q, clk_meta_d;
    logic          clk_sync_q, clk_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_meta_q, dat_meta_d;
    logic          dat_sync_q, dat_sync_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          irq_q, irq_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];

    logic fall_c;
    logic accept_c;
    logic reject_c;
    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // Two-stage synchronizers plus a delayed clock copy for fall detection.
    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_dat;
        dat_sync_d = dat_meta_q;
        fall_c     = clk_prev_q & ~clk_sync_q;
    end

    // Frame deserializer and abandon-on-idle timer.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        accept_c  = 1'b0;
        reject_c  = 1'b0;

        if (fall_c) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fall_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_sync_q && (^{shift_q, par_q})) begin
                        accept_c = 1'b1;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
        end
    end

    // FIFO control: a pop in the same cycle frees the slot for a push into a full queue.
    always_comb begin
        empty_c     = (wptr_q == rptr_q);
        full_c      = ((wptr_q ^ rptr_q) == FULL_XOR);
        pop_c       = bus.rd & ~empty_c;
        push_c      = accept_c & (~full_c | pop_c);
        drop_c      = accept_c & ~push_c;
        wptr_d      = push_c ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d      = pop_c ? (rptr_q + PW'(1)) : rptr_q;
        irq_d       = push_c;
        frame_err_d = reject_c;
        overflow_d  = overflow_q;
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (bus.clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            irq_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            dat_meta_q  <= dat_meta_d;
            dat_sync_q  <= dat_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            irq_q       <= irq_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
        end
    end

    assign bus.data      = empty_c ? 8'hFF : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    assign bus.ready     = ~empty_c;
    assign bus.irq       = irq_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of single frames plus overflow, timeout,
// pop-on-stop-edge and mid-frame reset sequences.
module tb_ps2_keyboard;
    localparam int unsigned TMO  = 300;
    localparam int          HALF = 30;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_keyboard_if bus ();

    ps2_keyboard #(
        .DEPTH_LOG2(4),
        .TIMEOUT   (TMO)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int irq_cnt  = 0;
    int ferr_cnt = 0;

    always @(posedge clock) begin
        if (bus.irq === 1'b1) irq_cnt++;
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] val;
        logic       par;
        logic       stp;
        int         exp_irq;
        int         exp_ferr;
        logic       exp_ready;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half-period.
    task automatic send_bit(input logic b, input bit rd_at_edge);
        ps2_dat = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        if (rd_at_edge) begin
            wait_cycles(2);
            bus.rd = 1'b1;
            wait_cycles(1);
            bus.rd = 1'b0;
            wait_cycles(HALF - 3);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic par, input logic stp,
                              input int nbits, input bit rd_on_stop);
        logic [10:0] bits;
        bits = {stp, par, v, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], rd_on_stop && (i == 10));
        end
        ps2_dat = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic good_frame(input logic [7:0] v);
        send_frame(v, ~(^v), 1'b1, 11, 1'b0);
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        wait_cycles(1);
        bus.rd = 1'b0;
    endtask

    initial begin
        int i0;
        int f0;
        logic [7:0] exp_b;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 1'b1, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 1'b0, 8'hFF};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 1'b1, 8'hF0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0, 1'b1, 8'hFF};
        vecs[5] = '{8'h5A, 1'b1, 1'b0, 0, 1, 1'b0, 8'hFF};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1, 0, 1'b1, 8'h80};

        bus.rd  = 1'b0;
        bus.clr = 1'b0;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(2);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_data", 32'(bus.data), 32'hFF);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);

        // Single-frame table
        for (int v = 0; v < 7; v++) begin
            i0 = irq_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].val, vecs[v].par, vecs[v].stp, 11, 1'b0);
            check($sformatf("vec%0d_irq", v), 32'(irq_cnt - i0), 32'(vecs[v].exp_irq));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ready", v), 32'(bus.ready), 32'(vecs[v].exp_ready));
            check($sformatf("vec%0d_data", v), 32'(bus.data), 32'(vecs[v].exp_data));
            if (vecs[v].exp_ready) begin
                pop();
                check($sformatf("vec%0d_pop_ready", v), 32'(bus.ready), 32'd0);
                check($sformatf("vec%0d_pop_data", v), 32'(bus.data), 32'hFF);
            end
        end

        // Overflow: 17 frames into 16 slots
        i0 = irq_cnt;
        for (int k = 1; k <= 17; k++) good_frame(8'(k));
        check("ovf_irqs", 32'(irq_cnt - i0), 32'd16);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("ovf_head%0d", k), 32'(bus.data), 32'(k));
            pop();
        end
        check("ovf_drained_ready", 32'(bus.ready), 32'd0);
        check("ovf_drained_data", 32'(bus.data), 32'hFF);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clr = 1'b1;
        wait_cycles(1);
        bus.clr = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Timeout: 5 bits, long idle, then a full frame
        i0 = irq_cnt;
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0);
        wait_cycles(2 * TMO);
        good_frame(8'h5A);
        check("tmo_irq", 32'(irq_cnt - i0), 32'd1);
        check("tmo_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("tmo_data", 32'(bus.data), 32'h5A);
        pop();
        check("tmo_only_one", 32'(bus.ready), 32'd0);

        // Full FIFO with a pop landing on the stop edge
        i0 = irq_cnt;
        for (int k = 0; k < 16; k++) good_frame(8'(8'h61 + k));
        check("full_irqs", 32'(irq_cnt - i0), 32'd16);
        send_frame(8'h77, 1'b1, 1'b1, 11, 1'b1);
        check("full_rd_irq", 32'(irq_cnt - i0), 32'd17);
        check("full_rd_ovf", 32'(bus.overflow), 32'd0);
        for (int k = 0; k < 16; k++) begin
            exp_b = (k < 15) ? 8'(8'h62 + k) : 8'h77;
            check($sformatf("full_drain%0d", k), 32'(bus.data), 32'(exp_b));
            pop();
        end
        check("full_drained_ready", 32'(bus.ready), 32'd0);

        // Reset during bit 4 with three bytes queued
        good_frame(8'h31);
        good_frame(8'h32);
        good_frame(8'h33);
        check("rstq_ready", 32'(bus.ready), 32'd1);
        check("rstq_head", 32'(bus.data), 32'h31);
        send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
        ps2_dat = 1'b0;
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        ps2_dat = 1'b1;
        wait_cycles(1);
        check("rstq_ready_after", 32'(bus.ready), 32'd0);
        check("rstq_data_after", 32'(bus.data), 32'hFF);
        wait_cycles(2 * HALF);
        i0 = irq_cnt;
        f0 = ferr_cnt;
        good_frame(8'h29);
        check("rstq_new_irq", 32'(irq_cnt - i0), 32'd1);
        check("rstq_new_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("rstq_new_data", 32'(bus.data), 32'h29);
        pop();
        check("rstq_new_empty", 32'(bus.ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
